// File: rtl/buffer_pkg.sv
// ============================================================================
// buffer_pkg : command/state encodings and lane helper for buffer_a_multi
// Rev 1.0
// ============================================================================
`default_nettype none

package buffer_pkg;

   localparam int DIM_W = 8;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_LOAD  = 2'b01,
      CMD_SEND  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      STATE_IDLE  = 2'b00,
      STATE_LOAD  = 2'b01,
      STATE_SEND  = 2'b10,
      STATE_CLEAR = 2'b11
   } state_e;

   // Bit offset of lane 'lane' inside a packed column of var_size-bit lanes.
   function automatic int lane_lsb(input int lane, input int var_size);
      return lane * var_size;
   endfunction

endpackage

`default_nettype wire

// File: rtl/operand_bank.sv
// ============================================================================
// operand_bank : MMU_SIZE columns x MMU_SIZE lanes storage, per-lane write,
//                combinational full-column read. Rev 1.0
// ============================================================================
`default_nettype none

module operand_bank
   import buffer_pkg::*;
#(
   parameter int VAR_SIZE = 8,
   parameter int MMU_SIZE = 10,
   parameter int ADDR_W   = 4
) (
   input  logic                         clk,
   input  logic [ADDR_W-1:0]            wr_col,
   input  logic [MMU_SIZE-1:0]          wr_en,
   input  logic [VAR_SIZE*MMU_SIZE-1:0] wr_data,
   input  logic [ADDR_W-1:0]            rd_col,
   output logic [VAR_SIZE*MMU_SIZE-1:0] rd_data
);

   // Contents are deliberately not reset; emptiness is tracked by the dims.
   logic [VAR_SIZE*MMU_SIZE-1:0] mem_q [MMU_SIZE];

   always_ff @(posedge clk) begin
      for (int i = 0; i < MMU_SIZE; i++) begin
         if (wr_en[i]) begin
            mem_q[wr_col][lane_lsb(i, VAR_SIZE) +: VAR_SIZE] <=
               wr_data[lane_lsb(i, VAR_SIZE) +: VAR_SIZE];
         end
      end
   end

   assign rd_data = mem_q[rd_col];

endmodule

`default_nettype wire

// File: rtl/buffer_a_multi.sv
// ============================================================================
// buffer_a_multi : multi-bank A-side operand buffer for the systolic MMU
//                  (element-wise LOAD, column-wise SEND, CLEAR). Rev 1.0
// ============================================================================
`default_nettype none

module buffer_a_multi
   import buffer_pkg::*;
#(
   parameter int VAR_SIZE = 8,
   parameter int MMU_SIZE = 10,
   parameter int NUM_BUF  = 10,
   parameter int BUF_W    = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd,
   input  logic [BUF_W-1:0]             cmd_buf,
   input  logic [7:0]                   cmd_dim_x,
   input  logic [7:0]                   cmd_dim_y,
   input  logic [VAR_SIZE-1:0]          in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [VAR_SIZE*MMU_SIZE-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   dim_x_out,
   output logic [7:0]                   dim_y_out,
   output logic                         done,
   output logic                         err
);

   localparam int LANES_W = VAR_SIZE * MMU_SIZE;
   localparam int ADDR_W  = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;

   state_e               state_q, state_d;
   logic [BUF_W-1:0]     buf_q, buf_d;
   logic [DIM_W-1:0]     row_q, row_d;
   logic [DIM_W-1:0]     col_q, col_d;
   logic [DIM_W-1:0]     cur_dx_q, cur_dx_d;
   logic [DIM_W-1:0]     cur_dy_q, cur_dy_d;
   logic [DIM_W-1:0]     dimx_q [NUM_BUF];
   logic [DIM_W-1:0]     dimx_d [NUM_BUF];
   logic [DIM_W-1:0]     dimy_q [NUM_BUF];
   logic [DIM_W-1:0]     dimy_d [NUM_BUF];
   logic [DIM_W-1:0]     dim_x_out_q, dim_x_out_d;
   logic [DIM_W-1:0]     dim_y_out_q, dim_y_out_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [MMU_SIZE-1:0]  lane_we;
   logic [LANES_W-1:0]   wr_data;
   logic [LANES_W-1:0]   col_rd [NUM_BUF];
   logic [LANES_W-1:0]   sel_rd;
   logic [LANES_W-1:0]   masked_rd;
   logic [DIM_W-1:0]     tgt_dx, tgt_dy;
   logic                 buf_bad, dims_bad;

   generate
      for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
         logic [MMU_SIZE-1:0] bank_we;
         assign bank_we = (buf_q == BUF_W'(b)) ? lane_we : '0;

         operand_bank #(
            .VAR_SIZE (VAR_SIZE),
            .MMU_SIZE (MMU_SIZE),
            .ADDR_W   (ADDR_W)
         ) u_bank (
            .clk     (clk),
            .wr_col  (col_q[ADDR_W-1:0]),
            .wr_en   (bank_we),
            .wr_data (wr_data),
            .rd_col  (col_q[ADDR_W-1:0]),
            .rd_data (col_rd[b])
         );
      end
   endgenerate

   // Bank lookups by compare rather than indexing, so NUM_BUF need not be a power of two.
   always_comb begin
      tgt_dx = '0;
      tgt_dy = '0;
      sel_rd = '0;
      for (int b = 0; b < NUM_BUF; b++) begin
         if (cmd_buf == BUF_W'(b)) begin
            tgt_dx = dimx_q[b];
            tgt_dy = dimy_q[b];
         end
         if (buf_q == BUF_W'(b)) begin
            sel_rd = col_rd[b];
         end
      end
   end

   assign buf_bad  = (32'(cmd_buf) >= 32'(NUM_BUF));
   assign dims_bad = (cmd_dim_x == '0) || (cmd_dim_x > DIM_W'(MMU_SIZE)) ||
                     (cmd_dim_y == '0) || (cmd_dim_y > DIM_W'(MMU_SIZE));

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      row_d       = row_q;
      col_d       = col_q;
      cur_dx_d    = cur_dx_q;
      cur_dy_d    = cur_dy_q;
      dimx_d      = dimx_q;
      dimy_d      = dimy_q;
      dim_x_out_d = dim_x_out_q;
      dim_y_out_d = dim_y_out_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      lane_we     = '0;
      wr_data     = '0;

      case (state_q)
         STATE_IDLE: begin
            if (cmd_valid) begin
               case (cmd_e'(cmd))
                  CMD_LOAD: begin
                     if (buf_bad || dims_bad) begin
                        err_d = 1'b1;
                     end else begin
                        buf_d       = cmd_buf;
                        row_d       = '0;
                        col_d       = '0;
                        cur_dx_d    = cmd_dim_x;
                        cur_dy_d    = cmd_dim_y;
                        dim_x_out_d = cmd_dim_x;
                        dim_y_out_d = cmd_dim_y;
                        for (int b = 0; b < NUM_BUF; b++) begin
                           if (cmd_buf == BUF_W'(b)) begin
                              dimx_d[b] = cmd_dim_x;
                              dimy_d[b] = cmd_dim_y;
                           end
                        end
                        state_d = STATE_LOAD;
                     end
                  end
                  CMD_SEND: begin
                     if (buf_bad || (tgt_dx == '0)) begin
                        err_d = 1'b1;
                     end else begin
                        buf_d       = cmd_buf;
                        col_d       = '0;
                        cur_dx_d    = tgt_dx;
                        cur_dy_d    = tgt_dy;
                        dim_x_out_d = tgt_dx;
                        dim_y_out_d = tgt_dy;
                        state_d     = STATE_SEND;
                     end
                  end
                  CMD_CLEAR: begin
                     if (buf_bad) begin
                        err_d = 1'b1;
                     end else begin
                        buf_d       = cmd_buf;
                        col_d       = '0;
                        dim_x_out_d = '0;
                        dim_y_out_d = '0;
                        for (int b = 0; b < NUM_BUF; b++) begin
                           if (cmd_buf == BUF_W'(b)) begin
                              dimx_d[b] = '0;
                              dimy_d[b] = '0;
                           end
                        end
                        state_d = STATE_CLEAR;
                     end
                  end
                  default: ;
               endcase
            end
         end

         STATE_LOAD: begin
            if (in_valid) begin
               wr_data = {MMU_SIZE{in_data}};
               for (int i = 0; i < MMU_SIZE; i++) begin
                  lane_we[i] = (row_q == DIM_W'(i));
               end
               if (row_q == cur_dx_q - 8'd1) begin
                  row_d = '0;
                  if (col_q == cur_dy_q - 8'd1) begin
                     state_d = STATE_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     col_d = col_q + 8'd1;
                  end
               end else begin
                  row_d = row_q + 8'd1;
               end
            end
         end

         STATE_SEND: begin
            if (out_ready) begin
               if (col_q == cur_dy_q - 8'd1) begin
                  state_d = STATE_IDLE;
                  done_d  = 1'b1;
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end

         STATE_CLEAR: begin
            lane_we = '1;
            if (col_q == DIM_W'(MMU_SIZE - 1)) begin
               state_d = STATE_IDLE;
               done_d  = 1'b1;
            end else begin
               col_d = col_q + 8'd1;
            end
         end

         default: state_d = STATE_IDLE;
      endcase
   end

   // Lanes at or beyond the stored row count read as zero, not stale memory.
   always_comb begin
      masked_rd = '0;
      if (state_q == STATE_SEND) begin
         for (int i = 0; i < MMU_SIZE; i++) begin
            if (DIM_W'(i) < cur_dx_q) begin
               masked_rd[lane_lsb(i, VAR_SIZE) +: VAR_SIZE] =
                  sel_rd[lane_lsb(i, VAR_SIZE) +: VAR_SIZE];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= STATE_IDLE;
         buf_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cur_dx_q    <= '0;
         cur_dy_q    <= '0;
         dim_x_out_q <= '0;
         dim_y_out_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         for (int b = 0; b < NUM_BUF; b++) begin
            dimx_q[b] <= '0;
            dimy_q[b] <= '0;
         end
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cur_dx_q    <= cur_dx_d;
         cur_dy_q    <= cur_dy_d;
         dim_x_out_q <= dim_x_out_d;
         dim_y_out_q <= dim_y_out_d;
         done_q      <= done_d;
         err_q       <= err_d;
         dimx_q      <= dimx_d;
         dimy_q      <= dimy_d;
      end
   end

   assign cmd_ready = (state_q == STATE_IDLE);
   assign in_ready  = (state_q == STATE_LOAD);
   assign out_valid = (state_q == STATE_SEND);
   assign out_data  = masked_rd;
   assign dim_x_out = dim_x_out_q;
   assign dim_y_out = dim_y_out_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_a_multi.sv
// ============================================================================
// tb_buffer_a_multi : directed self-checking bench for buffer_a_multi
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_buffer_a_multi;

   localparam int VS = 8;
   localparam int MS = 10;
   localparam int NB = 10;
   localparam int BW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd;
   logic [BW-1:0]     cmd_buf;
   logic [7:0]        cmd_dim_x;
   logic [7:0]        cmd_dim_y;
   logic [VS-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic [VS*MS-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        dim_x_out;
   logic [7:0]        dim_y_out;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: element [bank][col][row] and per-bank dims.
   logic [7:0] mdl [NB][MS][MS];
   int         mdx [NB];
   int         mdy [NB];
   int         last_dx = 0;
   int         last_dy = 0;

   always #5 clk = ~clk;

   buffer_a_multi #(
      .VAR_SIZE (VS),
      .MMU_SIZE (MS),
      .NUM_BUF  (NB),
      .BUF_W    (BW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_buf   (cmd_buf),
      .cmd_dim_x (cmd_dim_x),
      .cmd_dim_y (cmd_dim_y),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dim_x_out (dim_x_out),
      .dim_y_out (dim_y_out),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] exp_beat(input int b, input int c);
      logic [79:0] r;
      r = '0;
      for (int i = 0; i < mdx[b]; i++) r[i*VS +: VS] = mdl[b][c][i];
      return r;
   endfunction

   // Present a command for one cycle; returns on the negedge after the accept edge.
   task automatic issue(input logic [1:0] c, input int b, input int dx, input int dy);
      chk("cmd_ready_before_issue", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd       = c;
      cmd_buf   = BW'(b);
      cmd_dim_x = 8'(dx);
      cmd_dim_y = 8'(dy);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 2'b00;
   endtask

   task automatic do_load(input int b, input int dx, input int dy, input int base, input bit gaps);
      issue(2'b01, b, dx, dy);
      mdx[b] = dx; mdy[b] = dy; last_dx = dx; last_dy = dy;
      chk("load_in_ready", in_ready, 1);
      chk("load_cmd_ready_low", cmd_ready, 0);
      chk("load_dim_x_out", dim_x_out, 8'(dx));
      chk("load_dim_y_out", dim_y_out, 8'(dy));
      for (int k = 0; k < dx*dy; k++) begin
         if (gaps && (k % 2 == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'hAA;
            @(negedge clk);
            chk("load_stall_in_ready", in_ready, 1);
         end
         in_valid = 1'b1;
         in_data  = 8'(base + k);
         mdl[b][k/dx][k%dx] = 8'(base + k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("load_done", done, 1);
      chk("load_back_idle", in_ready, 0);
   endtask

   task automatic do_send(input int b, input logic [3:0] pat);
      int  j;
      int  cyc;
      logic rdy;
      issue(2'b10, b, 0, 0);
      last_dx = mdx[b]; last_dy = mdy[b];
      chk("send_dim_x_out", dim_x_out, 8'(mdx[b]));
      chk("send_dim_y_out", dim_y_out, 8'(mdy[b]));
      j = 0; cyc = 0;
      while (j < mdy[b] && cyc < 200) begin
         rdy       = pat[cyc % 4];
         out_ready = rdy;
         chk("send_out_valid", out_valid, 1);
         chk("send_beat", out_data, exp_beat(b, j));
         chk("send_no_early_done", done, 0);
         @(negedge clk);
         cyc++;
         if (rdy) j++;
      end
      out_ready = 1'b0;
      chk("send_done", done, 1);
      chk("send_out_valid_low", out_valid, 0);
      chk("send_out_data_zero", out_data, 0);
   endtask

   task automatic do_reject(input string tag, input logic [1:0] c, input int b, input int dx, input int dy);
      issue(c, b, dx, dy);
      chk({tag, "_err"}, err, 1);
      chk({tag, "_idle"}, cmd_ready, 1);
      chk({tag, "_no_load"}, in_ready, 0);
      chk({tag, "_no_send"}, out_valid, 0);
      chk({tag, "_no_done"}, done, 0);
      chk({tag, "_dim_x_kept"}, dim_x_out, 8'(last_dx));
      @(negedge clk);
      chk({tag, "_err_pulse"}, err, 0);
   endtask

   task automatic do_clear(input int b);
      issue(2'b11, b, 0, 0);
      mdx[b] = 0; mdy[b] = 0; last_dx = 0; last_dy = 0;
      for (int c = 0; c < MS; c++)
         for (int r = 0; r < MS; r++) mdl[b][c][r] = 8'h00;
      chk("clear_dim_x_out", dim_x_out, 0);
      chk("clear_dim_y_out", dim_y_out, 0);
      for (int k = 1; k <= MS; k++) begin
         chk("clear_cmd_ready_low", cmd_ready, 0);
         @(negedge clk);
         chk("clear_done_timing", done, (k == MS) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_buf = '0;
      cmd_dim_x = '0; cmd_dim_y = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      for (int b = 0; b < NB; b++) begin
         mdx[b] = 0; mdy[b] = 0;
      end
      repeat (2) @(negedge clk);

      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_dim_x_out", dim_x_out, 0);
      chk("rst_dim_y_out", dim_y_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full-size bank uses every lane.
      do_load(9, 10, 10, 1, 1'b0);
      do_send(9, 4'b1111);

      // 3x2 in bank 2: beats {1,2,3,0..} and {4,5,6,0..}, issued back-to-back.
      do_load(2, 3, 2, 1, 1'b0);
      chk("b2_beat0_direct", exp_beat(2, 0), 80'h03_02_01);
      do_send(2, 4'b1111);
      do_send(2, 4'b1001);

      // Gapped load of the same data must store the same values.
      do_load(2, 3, 2, 1, 1'b1);
      do_send(2, 4'b1111);

      // Single element, negative value.
      do_load(0, 1, 1, -5, 1'b0);
      do_send(0, 4'b1111);

      do_clear(2);
      do_reject("send_empty", 2'b10, 2, 0, 0);
      do_reject("buf_range", 2'b01, NB, 2, 2);
      do_reject("load_dx0", 2'b01, 3, 0, 2);
      do_reject("load_dy_big", 2'b01, 3, 2, MS + 1);

      // NONE is silent.
      issue(2'b00, 1, 0, 0);
      chk("none_no_err", err, 0);
      chk("none_idle", cmd_ready, 1);

      // Other banks survive the clear and the rejects.
      do_send(9, 4'b1111);
      do_send(0, 4'b1001);

      // Reset after 4 of 9 elements.
      issue(2'b01, 4, 3, 3);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(100 + k);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_dim_x_out", dim_x_out, 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      for (int b = 0; b < NB; b++) begin
         mdx[b] = 0; mdy[b] = 0;
      end
      last_dx = 0; last_dy = 0;
      @(negedge clk);
      chk("postrst_no_done", done, 0);
      do_load(4, 3, 3, 50, 1'b0);
      do_send(4, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
